// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and flag bundle for param_alu_core
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'd0;
   localparam logic [3:0] OP_OR    = 4'd1;
   localparam logic [3:0] OP_XOR   = 4'd2;
   localparam logic [3:0] OP_NOR   = 4'd3;
   localparam logic [3:0] OP_ADD   = 4'd4;
   localparam logic [3:0] OP_SUB   = 4'd5;
   localparam logic [3:0] OP_PASSA = 4'd6;
   localparam logic [3:0] OP_NOTA  = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_ASR   = 4'd10;
   localparam logic [3:0] OP_ROL   = 4'd11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic zero;
      logic neg;
      logic carry;
      logic ovf;
   } flags_t;

   function automatic logic is_shift(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

   function automatic logic is_illegal(input logic [3:0] op);
      return op[3:2] == 2'b11;
   endfunction

endpackage

// File: rtl/alu_comb_ops.sv
// rtl/alu_comb_ops.sv - single-cycle logic and add/sub results with carry/overflow
module alu_comb_ops
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             carry,
   output logic             ovf
);

   logic             sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // SUB is A + ~B + 1, so carry out doubles as the no-borrow indicator
   assign sub   = (op == OP_SUB);
   assign b_eff = sub ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

   always_comb begin
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op)
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         OP_XOR:   res = a ^ b;
         OP_NOR:   res = ~(a | b);
         OP_ADD, OP_SUB: begin
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
            ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_PASSA: res = a;
         OP_NOTA:  res = ~a;
         default:  res = '0;
      endcase
   end

endmodule

// File: rtl/param_alu_core.sv
// rtl/param_alu_core.sv - registered ALU with valid/ready handshake and iterative shifter
module param_alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inValid,
   output logic             inReady,
   input  logic [3:0]       opSel,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] result,
   output logic             flagZero,
   output logic             flagNeg,
   output logic             flagCarry,
   output logic             flagOvf,
   output logic             errIllegal,
   output logic             busy
);

   localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

   state_t             state, state_next;
   flags_t             flags_q;
   logic [WIDTH-1:0]   result_q;
   logic               err_q;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   work_step;
   logic               step_out;
   logic [SHAMT_W-1:0] cnt;
   logic [3:0]         op_q;
   logic [SHAMT_W-1:0] amt;
   logic               accept;
   logic               start_shift;
   logic               last_step;
   logic [WIDTH-1:0]   comb_res;
   logic               comb_carry;
   logic               comb_ovf;

   alu_comb_ops #(.WIDTH(WIDTH)) u_ops (
      .op    (opSel),
      .a     (inA),
      .b     (inB),
      .res   (comb_res),
      .carry (comb_carry),
      .ovf   (comb_ovf)
   );

   assign inReady     = !reset && ((state == IDLE) || ((state == HOLD) && outReady));
   assign accept      = inValid && inReady;
   assign amt         = inB[SHAMT_W-1:0];
   assign start_shift = accept && is_shift(opSel) && (amt != '0);
   assign last_step   = (state == SHIFT) && (cnt == CNT_ONE);

   assign outValid   = (state == HOLD);
   assign busy       = (state == SHIFT);
   assign result     = result_q;
   assign flagZero   = flags_q.zero;
   assign flagNeg    = flags_q.neg;
   assign flagCarry  = flags_q.carry;
   assign flagOvf    = flags_q.ovf;
   assign errIllegal = err_q;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = start_shift ? SHIFT : HOLD;
         SHIFT:   if (last_step) state_next = HOLD;
         HOLD: begin
            if (outReady) begin
               if (accept) state_next = start_shift ? SHIFT : HOLD;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      work_step = work;
      step_out  = 1'b0;
      case (op_q)
         OP_SHL: begin work_step = {work[WIDTH-2:0], 1'b0};         step_out = work[WIDTH-1]; end
         OP_SHR: begin work_step = {1'b0, work[WIDTH-1:1]};         step_out = work[0];       end
         OP_ASR: begin work_step = {work[WIDTH-1], work[WIDTH-1:1]}; step_out = work[0];      end
         default: begin work_step = {work[WIDTH-2:0], work[WIDTH-1]}; step_out = work[WIDTH-1]; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         flags_q  <= '0;
         err_q    <= 1'b0;
         work     <= '0;
         cnt      <= '0;
         op_q     <= '0;
      end else if (accept) begin
         if (start_shift) begin
            work <= inA;
            cnt  <= amt;
            op_q <= opSel;
         end else if (is_shift(opSel)) begin
            result_q      <= inA;
            flags_q.zero  <= (inA == '0);
            flags_q.neg   <= inA[WIDTH-1];
            flags_q.carry <= 1'b0;
            flags_q.ovf   <= 1'b0;
            err_q         <= 1'b0;
         end else if (is_illegal(opSel)) begin
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b1;
         end else begin
            result_q      <= comb_res;
            flags_q.zero  <= (comb_res == '0);
            flags_q.neg   <= comb_res[WIDTH-1];
            flags_q.carry <= comb_carry;
            flags_q.ovf   <= comb_ovf;
            err_q         <= 1'b0;
         end
      end else if (state == SHIFT) begin
         work <= work_step;
         cnt  <= cnt - CNT_ONE;
         if (last_step) begin
            result_q      <= work_step;
            flags_q.zero  <= (work_step == '0);
            flags_q.neg   <= work_step[WIDTH-1];
            flags_q.carry <= step_out;
            flags_q.ovf   <= 1'b0;
            err_q         <= 1'b0;
         end
      end
   end

endmodule

// File: doc/param_alu_core.md
Name: param_alu_core

Overview:
- Parametrised, registered successor to the 8-bit bitwise OR unit.
- Performs logic ops (AND/OR/XOR/NOR/NOT/PASS), add/subtract with flags, and multi-cycle shift/rotate.
- Uses valid/ready handshakes on input and output.
- Sits between operand registers and the writeback path, replacing the per-op combinational slices feeding the big result mux.

Parameters:
- WIDTH, 8, operand/result width; power of two, >= 4.
- SHAMT_W, $clog2(WIDTH), shift-amount field width taken from inB LSBs.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- inValid  input  1  operands and opSel valid
- inReady  output  1  core can accept an operation this cycle
- opSel  input  4  operation code (see Behaviour)
- inA  input  WIDTH  operand A
- inB  input  WIDTH  operand B; shifts use inB[SHAMT_W-1:0] as the amount
- outValid  output  1  result and flags valid
- outReady  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- flagZero / flagNeg / flagCarry / flagOvf  output  1 each  registered status flags
- errIllegal  output  1  registered; opSel was undefined
- busy  output  1  high while in SHIFT state

Behaviour:
- **Reset.** Synchronous and active-high on clk. All outputs become 0, state becomes IDLE, and inReady is 1 in the cycle after reset deasserts. Reset mid-operation abandons the operation: no outValid is produced for it.
- **States.**
  - IDLE: no result held.
  - SHIFT: iterating a shift/rotate.
  - HOLD: outValid=1, waiting for outReady.
- **Handshake.**
  - Accept = inValid & inReady.
  - inReady = (state==IDLE) | (state==HOLD & outReady), which is combinational from outReady.
  - In HOLD, result and flags stay stable until outReady=1.
  - HOLD & outReady & !accept -> IDLE.
  - HOLD & outReady & accept -> the new op starts (back-to-back, throughput 1 per cycle for single-cycle ops).
  - outReady with outValid=0 is ignored.
  - inValid is ignored while SHIFT.
- **Single-cycle opcodes.** 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 PASSA, 7 NOTA. The result is registered at accept and outValid=1 on the next cycle (latency 1).
- **Shift/rotate opcodes.** 8 SHL, 9 SHR (zero-fill), 10 ASR (sign-fill), 11 ROL.
  - At accept: load the working register with inA and the counter with the amount.
  - Each SHIFT cycle moves the register by 1 bit and decrements the counter.
  - When the counter reaches 0 -> HOLD.
  - Amount N >= 1 gives outValid N+1 cycles after accept.
  - Amount 0 goes directly to HOLD with result=inA and latency 1.
- **Illegal opcodes (12-15).** result=0, errIllegal=1, all flags 0, latency 1. errIllegal=0 for every legal op.
- **Flags** (computed on the final result, registered with it):
  - flagZero = (result==0).
  - flagNeg = result[WIDTH-1].
  - ADD: flagCarry = carry out of bit WIDTH-1; flagOvf = signed overflow.
  - SUB (A-B computed as A+~B+1): flagCarry = 1 when there is no borrow (A>=B unsigned); flagOvf = signed overflow.
  - Shifts and rotates: flagCarry = last bit shifted or rotated out (0 if amount 0); flagOvf = 0.
  - Logic ops: flagCarry = 0, flagOvf = 0.
- **Widths.** The add uses WIDTH+1 bits internally. The amount is an unsigned SHAMT_W-bit value, maximum WIDTH-1.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_AND..OP_ROL;
  - state encoding IDLE/SHIFT/HOLD;
  - a flag-bundle struct {zero, neg, carry, ovf}.
- Sub-module alu_comb_ops (combinational, parametrised by WIDTH) computes single-cycle op results plus carry/ovf.
- The top level holds the FSM, the shift datapath, the counter and the output registers.

Test Plan (WIDTH=8):
1. OR: A=0x5A, B=0x0F, op 1, outReady=1 -> outValid next cycle; result 0x5F; Z=0, C=0, V=0, errIllegal=0.
2. ADD: 0x7F+0x01 -> 0x80, N=1, V=1, C=0. Back-to-back ADD 0xFF+0x01 on the next cycle -> 0x00, Z=1, C=1, V=0. SUB 0x03-0x05 -> 0xFE, C=0, N=1.
3. Shifts:
   - ASR 0x90 by 3 -> outValid exactly 4 cycles after accept; result 0xF2, C=0; busy high for 3 cycles; inReady=0 throughout.
   - ROL 0x81 by 1 -> 0x03, C=1.
   - SHL 0x55 by 0 -> 0x55, latency 1, C=0.
4. Backpressure: hold outReady=0 for 5 cycles after a result -> result and flags unchanged, inReady=0. Then raise outReady in the same cycle as a new inValid (XOR 0xF0^0xFF) -> accepted; next cycle result 0x0F.
5. Reset mid-shift: SHL 0x01 by 7, assert reset on the 3rd SHIFT cycle -> next cycle outValid=0, result=0, busy=0; inReady=1 after reset drops; no stale result ever appears.
6. Illegal: op 12 with A=0xFF -> result 0x00, errIllegal=1, Z=0, all other flags 0; the next legal op clears errIllegal.
